// File: rtl/player_walk_ctrl.sv
// Grid-locked player walk sequencer: turns key requests into tile steps,
// paced one pixel per frame, each step gated by a map ROM collision probe.
module player_walk_ctrl #(
    parameter int STEP_PIXELS = 16,
    parameter int TURN_FRAMES = 4,
    parameter int CHECK_LAT   = 1,
    parameter int MAP_W       = 32,
    parameter int MAP_H       = 32,
    parameter int START_X     = 0,
    parameter int START_Y     = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Frame_Tick,
    input  logic       Key_Valid,
    input  logic [1:0] Key_Dir,
    input  logic       Blocked,
    output logic [4:0] Probe_X,
    output logic [4:0] Probe_Y,
    output logic       Character_Moving,
    output logic [1:0] Direction,
    output logic [1:0] Anim_Frame,
    output logic [5:0] Scroll_Offset,
    output logic [4:0] Tile_X,
    output logic [4:0] Tile_Y,
    output logic       Step_Done,
    output logic       Bump
);

    localparam int TW = $clog2(TURN_FRAMES + 1);
    localparam logic [5:0] LAST = 6'(STEP_PIXELS - 1);
    localparam logic [5:0] HALF = 6'(STEP_PIXELS / 2);
    localparam logic [1:0] REST1 = 2'd0, REST2 = 2'd1, M1 = 2'd2, M2 = 2'd3;

    typedef enum logic [1:0] {IDLE, TURN, CHECK, WALK} state_t;

    state_t         state, state_n;
    logic [TW-1:0]  turn_cnt, turn_n;
    logic [1:0]     chk_cnt, chk_n;
    logic           oob, oob_n, foot, foot_n, chain, chain_n;
    logic [4:0]     px_n, py_n, tx_n, ty_n;
    logic [1:0]     dir_n, anim_n;
    logic [5:0]     scroll_n;
    logic           moving_n, step_n, bump_n;
    logic [10:0]    nb_tile, nb_probe;

    // Neighbour tile in direction d, with an out-of-map flag in the MSB.
    // The flag is what refuses the move, so the wrapped coordinate is harmless.
    function automatic logic [10:0] nbr(input logic [1:0] d, input logic [4:0] x, input logic [4:0] y);
        logic [5:0] nx, ny;
        logic       o;
        nx = {1'b0, x};
        ny = {1'b0, y};
        o  = 1'b0;
        case (d)
            2'd0: begin o = (y == 5'd0); ny = ny - 6'd1; end
            2'd1: begin nx = nx + 6'd1; o = (nx >= 6'(MAP_W)); end
            2'd2: begin ny = ny + 6'd1; o = (ny >= 6'(MAP_H)); end
            default: begin o = (x == 5'd0); nx = nx - 6'd1; end
        endcase
        return {o, nx[4:0], ny[4:0]};
    endfunction

    assign nb_tile  = nbr(Direction, Tile_X, Tile_Y);
    assign nb_probe = nbr(Direction, Probe_X, Probe_Y);

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_n  = state;
        turn_n   = turn_cnt;
        chk_n    = chk_cnt;
        oob_n    = oob;
        foot_n   = foot;
        chain_n  = chain;
        px_n     = Probe_X;
        py_n     = Probe_Y;
        tx_n     = Tile_X;
        ty_n     = Tile_Y;
        dir_n    = Direction;
        scroll_n = Scroll_Offset;
        step_n   = 1'b0;
        bump_n   = 1'b0;
        case (state)
            IDLE: if (Frame_Tick && Key_Valid) begin
                if (Key_Dir != Direction) begin
                    dir_n   = Key_Dir;
                    turn_n  = '0;
                    state_n = TURN;
                end else begin
                    {oob_n, px_n, py_n} = nb_tile;
                    chk_n   = 2'd0;
                    chain_n = 1'b0;
                    state_n = CHECK;
                end
            end
            TURN: if (Frame_Tick) begin
                if (turn_cnt == TW'(TURN_FRAMES - 1)) state_n = IDLE;
                else turn_n = turn_cnt + TW'(1);
            end
            CHECK: begin
                if (chk_cnt == 2'(CHECK_LAT - 1)) begin
                    if (oob || Blocked) begin
                        bump_n  = 1'b1;
                        chain_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        scroll_n = 6'd0;
                        state_n  = WALK;
                    end
                end else begin
                    chk_n = chk_cnt + 2'd1;
                end
            end
            WALK: if (Frame_Tick) begin
                if (Scroll_Offset == LAST) begin
                    tx_n     = Probe_X;
                    ty_n     = Probe_Y;
                    scroll_n = 6'd0;
                    step_n   = 1'b1;
                    foot_n   = ~foot;
                    if (Key_Valid && Key_Dir == Direction) begin
                        {oob_n, px_n, py_n} = nb_probe;
                        chk_n   = 2'd0;
                        chain_n = 1'b1;
                        state_n = CHECK;
                    end else begin
                        chain_n = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
                    scroll_n = Scroll_Offset + 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        moving_n = (state_n == WALK) || (state_n == CHECK && chain_n);
        if (state_n == WALK)
            anim_n = (scroll_n < HALF) ? (foot_n ? M2 : M1) : (foot_n ? REST1 : REST2);
        else if (state_n == CHECK && chain_n)
            anim_n = Anim_Frame;
        else
            anim_n = REST1;
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state            <= IDLE;
            turn_cnt         <= '0;
            chk_cnt          <= 2'd0;
            oob              <= 1'b0;
            foot             <= 1'b0;
            chain            <= 1'b0;
            Probe_X          <= 5'(START_X);
            Probe_Y          <= 5'(START_Y);
            Tile_X           <= 5'(START_X);
            Tile_Y           <= 5'(START_Y);
            Direction        <= 2'd0;
            Scroll_Offset    <= 6'd0;
            Anim_Frame       <= REST1;
            Character_Moving <= 1'b0;
            Step_Done        <= 1'b0;
            Bump             <= 1'b0;
        end else begin
            state            <= state_n;
            turn_cnt         <= turn_n;
            chk_cnt          <= chk_n;
            oob              <= oob_n;
            foot             <= foot_n;
            chain            <= chain_n;
            Probe_X          <= px_n;
            Probe_Y          <= py_n;
            Tile_X           <= tx_n;
            Tile_Y           <= ty_n;
            Direction        <= dir_n;
            Scroll_Offset    <= scroll_n;
            Anim_Frame       <= anim_n;
            Character_Moving <= moving_n;
            Step_Done        <= step_n;
            Bump             <= bump_n;
        end
    end

endmodule

// File: tb/tb_player_walk_ctrl.sv
// Directed bench for player_walk_ctrl: walk, turn, collision, map edge,
// chained steps and mid-step reset, starting from tile (5,5).
module tb_player_walk_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Frame_Tick = 1'b0;
    logic       Key_Valid = 1'b0;
    logic [1:0] Key_Dir = 2'd0;
    logic       Blocked = 1'b0;
    logic [4:0] Probe_X, Probe_Y, Tile_X, Tile_Y;
    logic       Character_Moving, Step_Done, Bump;
    logic [1:0] Direction, Anim_Frame;
    logic [5:0] Scroll_Offset;

    int total = 0;
    int fails = 0;
    int foot  = 0;

    player_walk_ctrl #(.START_X(5), .START_Y(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick(Frame_Tick),
        .Key_Valid(Key_Valid), .Key_Dir(Key_Dir), .Blocked(Blocked),
        .Probe_X(Probe_X), .Probe_Y(Probe_Y),
        .Character_Moving(Character_Moving), .Direction(Direction),
        .Anim_Frame(Anim_Frame), .Scroll_Offset(Scroll_Offset),
        .Tile_X(Tile_X), .Tile_Y(Tile_Y), .Step_Done(Step_Done), .Bump(Bump)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One idle cycle, then a one-cycle Frame_Tick; returns just after the tick edge.
    task automatic tick();
        cyc(1);
        Frame_Tick = 1'b1;
        cyc(1);
        Frame_Tick = 1'b0;
    endtask

    function automatic int first_half(input int f);
        return f ? 3 : 2;
    endfunction

    function automatic int second_half(input int f);
        return f ? 0 : 1;
    endfunction

    task automatic check_reset_state(input string p);
        chk({p, "_tx"}, Tile_X, 5);
        chk({p, "_ty"}, Tile_Y, 5);
        chk({p, "_px"}, Probe_X, 5);
        chk({p, "_py"}, Probe_Y, 5);
        chk({p, "_dir"}, Direction, 0);
        chk({p, "_scroll"}, Scroll_Offset, 0);
        chk({p, "_anim"}, Anim_Frame, 0);
        chk({p, "_moving"}, Character_Moving, 0);
        chk({p, "_done"}, Step_Done, 0);
        chk({p, "_bump"}, Bump, 0);
    endtask

    initial begin
        // Reset
        cyc(2);
        check_reset_state("rst");
        Reset_n = 1'b1;
        cyc(1);

        // Single step up from (5,5)
        Key_Valid = 1'b1; Key_Dir = 2'd0;
        tick();
        chk("up_probe_x", Probe_X, 5);
        chk("up_probe_y", Probe_Y, 4);
        chk("up_check_moving", Character_Moving, 0);
        cyc(1);
        Key_Valid = 1'b0;
        chk("up_walk_moving", Character_Moving, 1);
        chk("up_walk_scroll0", Scroll_Offset, 0);
        chk("up_walk_anim0", Anim_Frame, 2);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("up_scroll", Scroll_Offset, i);
            chk("up_anim", Anim_Frame, (i < 8) ? 2 : 1);
            chk("up_done_early", Step_Done, 0);
        end
        tick();
        chk("up_done", Step_Done, 1);
        chk("up_tile_x", Tile_X, 5);
        chk("up_tile_y", Tile_Y, 4);
        chk("up_end_scroll", Scroll_Offset, 0);
        chk("up_end_moving", Character_Moving, 0);
        chk("up_end_anim", Anim_Frame, 0);
        foot = 1;
        cyc(1);
        chk("up_done_width", Step_Done, 0);

        // Turn right: direction changes on the tick, then 4 ticks in place
        Key_Valid = 1'b1; Key_Dir = 2'd1;
        tick();
        chk("turn_dir", Direction, 1);
        chk("turn_moving0", Character_Moving, 0);
        Key_Valid = 1'b0; Key_Dir = 2'd2;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("turn_moving", Character_Moving, 0);
            chk("turn_dir_hold", Direction, 1);
            chk("turn_tile_x", Tile_X, 5);
        end
        Key_Valid = 1'b1; Key_Dir = 2'd1;
        tick();
        chk("turn_last_probe", Probe_X, 5);
        chk("turn_last_dir", Direction, 1);

        // Collision: probe (6,4) reported blocked
        tick();
        chk("blk_probe_x", Probe_X, 6);
        chk("blk_probe_y", Probe_Y, 4);
        Blocked = 1'b1; Key_Valid = 1'b0;
        cyc(1);
        chk("blk_bump", Bump, 1);
        chk("blk_done", Step_Done, 0);
        chk("blk_tile_x", Tile_X, 5);
        chk("blk_anim", Anim_Frame, 0);
        chk("blk_moving", Character_Moving, 0);
        cyc(1);
        chk("blk_bump_width", Bump, 0);
        Blocked = 1'b0;

        // Turn left, then hold the key for five chained steps down to X=0
        Key_Valid = 1'b1; Key_Dir = 2'd3;
        tick();
        chk("left_dir", Direction, 3);
        repeat (4) tick();
        tick();
        chk("chain_probe_x", Probe_X, 4);
        cyc(1);
        chk("chain_moving_start", Character_Moving, 1);
        chk("chain_anim_start", Anim_Frame, first_half(foot));
        for (int s = 0; s < 5; s++) begin
            for (int i = 1; i < 16; i++) begin
                tick();
                chk("chain_moving", Character_Moving, 1);
                chk("chain_scroll", Scroll_Offset, i);
                chk("chain_anim", Anim_Frame, (i < 8) ? first_half(foot) : second_half(foot));
                chk("chain_done_early", Step_Done, 0);
            end
            tick();
            chk("chain_done", Step_Done, 1);
            chk("chain_bump_excl", Bump, 0);
            chk("chain_tile_x", Tile_X, 4 - s);
            chk("chain_chk_moving", Character_Moving, 1);
            chk("chain_chk_anim", Anim_Frame, second_half(foot));
            foot = 1 - foot;
            cyc(1);
            chk("chain_done_width", Step_Done, 0);
            if (s < 4) begin
                chk("chain_walk_moving", Character_Moving, 1);
                chk("chain_walk_scroll0", Scroll_Offset, 0);
                chk("chain_walk_anim0", Anim_Frame, first_half(foot));
            end else begin
                chk("edge_bump", Bump, 1);
                chk("edge_moving", Character_Moving, 0);
                chk("edge_tile_x", Tile_X, 0);
                chk("edge_anim", Anim_Frame, 0);
            end
        end
        Key_Valid = 1'b0;
        cyc(1);
        chk("edge_bump_width", Bump, 0);

        // Reset at Scroll_Offset=9 mid-step
        Key_Valid = 1'b1; Key_Dir = 2'd1;
        tick();
        repeat (4) tick();
        tick();
        chk("rw_probe_x", Probe_X, 1);
        cyc(1);
        Key_Valid = 1'b0;
        repeat (9) tick();
        chk("rw_scroll9", Scroll_Offset, 9);
        Reset_n = 1'b0;
        cyc(1);
        check_reset_state("rw");
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rw_no_done", Step_Done, 0);
            chk("rw_scroll_idle", Scroll_Offset, 0);
            chk("rw_tile_x", Tile_X, 5);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
